// File: rtl/vid_fill_port_pkg.sv
// Shared definitions for the video write port: register offsets, command/status
// bit positions and the fill engine state encoding.
package vid_fill_port_pkg;

  localparam logic [2:0] REG_ADDR   = 3'd0;
  localparam logic [2:0] REG_BANK_R = 3'd1;
  localparam logic [2:0] REG_BANK_W = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_WIDTH  = 3'd4;
  localparam logic [2:0] REG_HEIGHT = 3'd5;
  localparam logic [2:0] REG_COLOR  = 3'd6;
  localparam logic [2:0] REG_CMD    = 3'd7;

  localparam int CMD_START_BIT   = 0;
  localparam int CMD_CLR_ERR_BIT = 7;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_ERR_BIT    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // 16-bit registers are loaded a byte at a time, high byte first.
  function automatic logic [15:0] shift_in(input logic [15:0] cur, input logic [7:0] b);
    return {cur[7:0], b};
  endfunction

endpackage

// File: rtl/vid_fill_engine.sv
// Rectangle fill engine: latches a rectangle on start and emits one pixel write
// per cycle in row-major order while busy.
module vid_fill_engine
  import vid_fill_port_pkg::*;
#(
  parameter logic [15:0] STRIDE = 16'd320
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  input  logic [7:0]  color_i,
  output logic        busy_o,
  output logic [15:0] pix_addr_o,
  output logic [7:0]  pix_data_o
);

  fill_state_e state_q, state_d;
  logic [15:0] row_start_q, row_start_d;
  logic [15:0] pix_addr_q, pix_addr_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] w_q, w_d;
  logic [15:0] h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic        last_col;
  logic        last_row;

  assign last_col = (x_q == w_q - 16'd1);
  assign last_row = (y_q == h_q - 16'd1);

  always_comb begin
    state_d     = state_q;
    row_start_d = row_start_q;
    pix_addr_d  = pix_addr_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_FILL;
          w_d         = width_i;
          h_d         = height_i;
          color_d     = color_i;
          row_start_d = addr_i;
          pix_addr_d  = addr_i;
          x_d         = 16'd0;
          y_d         = 16'd0;
        end
      end
      ST_FILL: begin
        if (last_col) begin
          x_d = 16'd0;
          if (last_row) begin
            state_d = ST_IDLE;
          end else begin
            y_d         = y_q + 16'd1;
            row_start_d = row_start_q + STRIDE;
            pix_addr_d  = row_start_q + STRIDE;
          end
        end else begin
          x_d        = x_q + 16'd1;
          pix_addr_d = pix_addr_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      row_start_q <= 16'd0;
      pix_addr_q  <= 16'd0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      w_q         <= 16'd0;
      h_q         <= 16'd0;
      color_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      row_start_q <= row_start_d;
      pix_addr_q  <= pix_addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
    end
  end

  assign busy_o     = (state_q == ST_FILL);
  assign pix_addr_o = pix_addr_q;
  assign pix_data_o = color_q;

endmodule

// File: rtl/vid_fill_port.sv
// CPU-facing video RAM write port: register decode, auto-increment single writes,
// bank selects and the write-side mux between CPU writes and the fill engine.
module vid_fill_port
  import vid_fill_port_pkg::*;
#(
  parameter logic [15:0] BASE   = 16'h0020,
  parameter logic [15:0] STRIDE = 16'd320
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  data_i,
  input  logic        we,
  output logic [7:0]  data_o,
  output logic        busy,
  output logic        bank_r,
  output logic        bank_w,
  output logic [15:0] vid_address,
  output logic [7:0]  vid_data,
  output logic        vid_we
);

  logic [15:0] offset;
  logic        in_window;
  logic [7:0]  wr_hit;

  logic [15:0] addr_q, addr_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [7:0]  color_q, color_d;
  logic        bank_r_q, bank_r_d;
  logic        bank_w_q, bank_w_d;
  logic        err_q, err_d;
  logic        dwe_q, dwe_d;
  logic [15:0] dwaddr_q, dwaddr_d;
  logic [7:0]  dwdata_q, dwdata_d;

  logic        eng_busy;
  logic        eng_start;
  logic [15:0] eng_addr;
  logic [7:0]  eng_data;
  logic        data_wr;
  logic        start_req;
  logic [7:0]  status;

  // Offset-based decode keeps the window correct for any BASE alignment.
  assign offset    = address - BASE;
  assign in_window = (offset[15:3] == 13'd0);

  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign wr_hit[gi] = we && in_window && (offset[2:0] == 3'(gi));
  end

  assign data_wr   = wr_hit[REG_DATA];
  assign start_req = wr_hit[REG_CMD] && data_i[CMD_START_BIT];
  assign eng_start = start_req && !eng_busy && (width_q != 16'd0) && (height_q != 16'd0);

  always_comb begin
    addr_d   = addr_q;
    width_d  = width_q;
    height_d = height_q;
    color_d  = color_q;
    bank_r_d = bank_r_q;
    bank_w_d = bank_w_q;
    err_d    = err_q;
    dwe_d    = 1'b0;
    dwaddr_d = dwaddr_q;
    dwdata_d = dwdata_q;

    if (wr_hit[REG_ADDR]) begin
      addr_d = shift_in(addr_q, data_i);
    end else if (data_wr && !eng_busy) begin
      addr_d = addr_q + 16'd1;
    end
    if (wr_hit[REG_BANK_R]) bank_r_d = data_i[0];
    if (wr_hit[REG_BANK_W]) bank_w_d = data_i[0];
    if (wr_hit[REG_WIDTH])  width_d  = shift_in(width_q, data_i);
    if (wr_hit[REG_HEIGHT]) height_d = shift_in(height_q, data_i);
    if (wr_hit[REG_COLOR])  color_d  = data_i;

    if (data_wr && !eng_busy) begin
      dwe_d    = 1'b1;
      dwaddr_d = addr_q;
      dwdata_d = data_i;
    end

    // Clear is applied before the busy check so a combined clear+start while
    // busy still leaves the error flagged.
    if (wr_hit[REG_CMD] && data_i[CMD_CLR_ERR_BIT]) err_d = 1'b0;
    if ((data_wr || start_req) && eng_busy) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 16'd0;
      width_q  <= 16'd0;
      height_q <= 16'd0;
      color_q  <= 8'd0;
      bank_r_q <= 1'b0;
      bank_w_q <= 1'b0;
      err_q    <= 1'b0;
      dwe_q    <= 1'b0;
      dwaddr_q <= 16'd0;
      dwdata_q <= 8'd0;
    end else begin
      addr_q   <= addr_d;
      width_q  <= width_d;
      height_q <= height_d;
      color_q  <= color_d;
      bank_r_q <= bank_r_d;
      bank_w_q <= bank_w_d;
      err_q    <= err_d;
      dwe_q    <= dwe_d;
      dwaddr_q <= dwaddr_d;
      dwdata_q <= dwdata_d;
    end
  end

  vid_fill_engine #(
    .STRIDE (STRIDE)
  ) u_engine (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .start_i    (eng_start),
    .addr_i     (addr_q),
    .width_i    (width_q),
    .height_i   (height_q),
    .color_i    (color_q),
    .busy_o     (eng_busy),
    .pix_addr_o (eng_addr),
    .pix_data_o (eng_data)
  );

  // CPU writes are refused while filling, so the two sources never overlap.
  assign vid_we      = eng_busy | dwe_q;
  assign vid_address = eng_busy ? eng_addr : dwaddr_q;
  assign vid_data    = eng_busy ? eng_data : dwdata_q;

  always_comb begin
    status                = 8'h00;
    status[STAT_BUSY_BIT] = eng_busy;
    status[STAT_ERR_BIT]  = err_q;
  end

  assign data_o = (offset == 16'd7) ? status : 8'h00;
  assign busy   = eng_busy;
  assign bank_r = bank_r_q;
  assign bank_w = bank_w_q;

endmodule

// File: tb/tb_vid_fill_port.sv
// Randomised self-checking bench for vid_fill_port against a queue-based model of
// the expected video RAM write stream and status register.
module tb_vid_fill_port;

  localparam logic [15:0] BASE   = 16'h0020;
  localparam logic [15:0] STRIDE = 16'd320;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_i = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  data_o;
  logic        busy;
  logic        bank_r;
  logic        bank_w;
  logic [15:0] vid_address;
  logic [7:0]  vid_data;
  logic        vid_we;

  vid_fill_port #(
    .BASE   (BASE),
    .STRIDE (STRIDE)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .data_i      (data_i),
    .we          (we),
    .data_o      (data_o),
    .busy        (busy),
    .bank_r      (bank_r),
    .bank_w      (bank_w),
    .vid_address (vid_address),
    .vid_data    (vid_data),
    .vid_we      (vid_we)
  );

  always #20 clock = ~clock;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  obs_base = 0;
  int  busy_cnt = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  logic [15:0] m_addr, m_w, m_h;
  logic [7:0]  m_color;

  always @(negedge clock) begin
    if (reset_n) begin
      if (vid_we) obs_q.push_back({vid_address, vid_data});
      if (busy) busy_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    address = BASE + 16'(off);
    data_i  = d;
    we      = 1'b1;
    @(negedge clock);
    we      = 1'b0;
    address = 16'h0000;
    data_i  = 8'h00;
  endtask

  task automatic set16(input logic [2:0] off, input logic [15:0] v);
    wr(off, v[15:8]);
    wr(off, v[7:0]);
  endtask

  task automatic read_status(output logic [7:0] v);
    address = BASE + 16'd7;
    #1;
    v = data_o;
    address = 16'h0000;
  endtask

  task automatic settle();
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while (busy && i < bound) begin
      @(negedge clock);
      i++;
    end
    if (busy) check_eq("fill_timeout", 32'(busy), 32'd0);
  endtask

  function automatic void model_fill(input logic [15:0] a, input logic [15:0] w,
                                     input logic [15:0] h, input logic [7:0] c);
    wr_t e;
    for (int y = 0; y < int'(h); y++) begin
      for (int x = 0; x < int'(w); x++) begin
        e.a = 16'(int'(a) + y * int'(STRIDE) + x);
        e.d = c;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic op_addr(input logic [15:0] v);
    set16(3'd0, v);
    m_addr = v;
  endtask

  task automatic op_data(input logic [7:0] d);
    wr_t e;
    wr(3'd3, d);
    e.a = m_addr;
    e.d = d;
    exp_q.push_back(e);
    m_addr = m_addr + 16'd1;
  endtask

  task automatic op_rect(input logic [15:0] w, input logic [15:0] h, input logic [7:0] c);
    set16(3'd4, w);
    set16(3'd5, h);
    wr(3'd6, c);
    m_w = w;
    m_h = h;
    m_color = c;
  endtask

  task automatic op_start(input logic [7:0] cmd);
    wr(3'd7, cmd);
    if (m_w != 16'd0 && m_h != 16'd0) model_fill(m_addr, m_w, m_h, m_color);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    n = obs_q.size() - obs_base;
    check_eq({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check_eq({tag, "_addr"}, 32'(obs_q[obs_base + i].a), 32'(exp_q[i].a));
      check_eq({tag, "_data"}, 32'(obs_q[obs_base + i].d), 32'(exp_q[i].d));
    end
    $display("txn %s: %0d writes observed, %0d expected", tag, n, exp_q.size());
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  st;
    int          b0;
    logic [15:0] w, h, a;
    logic [7:0]  br, bw;

    m_addr = 16'h0000; m_w = 16'h0000; m_h = 16'h0000; m_color = 8'h00;

    // Reset state
    #1;
    check_eq("rst_vid_we", 32'(vid_we), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_vid_address", 32'(vid_address), 32'd0);
    read_status(st);
    check_eq("rst_status", 32'(st), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: ADDR shift-in, single DATA write, auto-increment
    op_addr(16'h1234);
    op_data(8'hAB);
    settle();
    compare_writes("t1_data");
    op_data(8'hCD);
    settle();
    compare_writes("t1_incr");

    // 2: auto-increment wraps at 0xFFFF
    op_addr(16'hFFFF);
    op_data(8'h11);
    op_data(8'h22);
    settle();
    compare_writes("t2_wrap");

    // 3: 3x2 fill at 100
    op_addr(16'd100);
    op_rect(16'd3, 16'd2, 8'h0F);
    b0 = busy_cnt;
    op_start(8'h01);
    wait_idle(200);
    settle();
    compare_writes("t3_fill");
    check_eq("t3_busy_cycles", 32'(busy_cnt - b0), 32'd6);

    // 4: zero width start is a no-op
    op_rect(16'd0, 16'd5, 8'h44);
    b0 = busy_cnt;
    op_start(8'h01);
    settle();
    compare_writes("t4_nofill");
    check_eq("t4_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    read_status(st);
    check_eq("t4_status", 32'(st), 32'h00);

    // 5: writes during fill raise ERR and do not disturb the fill
    op_addr(16'd500);
    op_rect(16'd4, 16'd3, 8'h77);
    op_start(8'h01);
    wr(3'd3, 8'h99);
    wr(3'd7, 8'h01);
    read_status(st);
    check_eq("t5_status_busy", 32'(st), 32'h03);
    wait_idle(200);
    settle();
    compare_writes("t5_fill");
    read_status(st);
    check_eq("t5_status_err", 32'(st), 32'h02);
    address = BASE + 16'd6;
    #1;
    check_eq("t5_data_o_other", 32'(data_o), 32'h00);
    address = 16'h0000;
    wr(3'd7, 8'h80);
    read_status(st);
    check_eq("t5_status_clr", 32'(st), 32'h00);
    op_data(8'h5E);
    settle();
    compare_writes("t5_addr_kept");
    op_rect(16'd2, 16'd2, 8'h33);
    op_start(8'h01);
    wr(3'd3, 8'h44);
    wait_idle(200);
    read_status(st);
    check_eq("t5_status_err2", 32'(st), 32'h02);
    op_start(8'h81);
    wait_idle(200);
    settle();
    compare_writes("t5_clr_start");
    read_status(st);
    check_eq("t5_status_end", 32'(st), 32'h00);

    // Randomised operations against the model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 700))
                                          : 16'($urandom);
          op_addr(a);
        end
        1: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) op_data(8'($urandom));
        end
        2: begin
          w = 16'($urandom_range(0, 4));
          h = 16'($urandom_range(0, 4));
          op_rect(w, h, 8'($urandom));
          b0 = busy_cnt;
          op_start(8'h01);
          wait_idle(200);
          settle();
          check_eq("rnd_busy_cycles", 32'(busy_cnt - b0), 32'(w) * 32'(h));
        end
        default: begin
          br = 8'($urandom);
          bw = 8'($urandom);
          wr(3'd1, br);
          wr(3'd2, bw);
          settle();
          check_eq("rnd_bank_r", 32'(bank_r), 32'(br[0]));
          check_eq("rnd_bank_w", 32'(bank_w), 32'(bw[0]));
        end
      endcase
      settle();
      compare_writes("rnd");
    end

    // 6: asynchronous reset in the middle of a large fill
    op_addr(16'd0);
    op_rect(16'd320, 16'd200, 8'hEE);
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h01);
    wr(3'd7, 8'h01);
    repeat (20) @(negedge clock);
    check_eq("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_vid_we_rst", 32'(vid_we), 32'd0);
    check_eq("t6_busy_rst", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    settle();
    obs_base = obs_q.size();
    exp_q.delete();
    m_addr = 16'h0000; m_w = 16'h0000; m_h = 16'h0000; m_color = 8'h00;
    check_eq("t6_bank_r", 32'(bank_r), 32'd0);
    check_eq("t6_bank_w", 32'(bank_w), 32'd0);
    check_eq("t6_vid_address", 32'(vid_address), 32'd0);
    check_eq("t6_vid_data", 32'(vid_data), 32'd0);
    read_status(st);
    check_eq("t6_status", 32'(st), 32'h00);
    b0 = busy_cnt;
    op_start(8'h01);
    settle();
    check_eq("t6_no_fill", 32'(busy_cnt - b0), 32'd0);
    op_data(8'h5A);
    set16(3'd4, 16'd1);
    set16(3'd5, 16'd1);
    m_w = 16'd1;
    m_h = 16'd1;
    op_start(8'h01);
    wait_idle(50);
    settle();
    compare_writes("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
